period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures an incoming slow square wave, such as a prescaler-divided clock or a button/dice tick stream, in cycles of the system clock.
- Reports full period and high time, so the divide factor of a divider clocked from the same clock is recovered as high_time.
- Used as the on-board checker for divided clocks in the dice design and as a debug readout source.

Parameters:
- CNT_W, 32, width of period/high_time counters and outputs.
- TIMEOUT_CYC, 50000000, clk_in cycles without a rising edge before timeout is declared; must be < 2^CNT_W.
- SYNC_STAGES, 2, flip-flop stages synchronizing sig_in (min 2).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  measured signal, asynchronous to clk_in.
- meas_en  input  1  measurement enable; low forces IDLE.
- period  output  CNT_W  clk_in cycles between the last two rising edges of sig_in.
- high_time  output  CNT_W  clk_in cycles sig_in was high within that period.
- period_valid  output  1  one-cycle pulse when period/high_time update.
- timeout  output  1  sticky flag; no rising edge within TIMEOUT_CYC.
- busy  output  1  high in ARM or MEASURE.

Behaviour:
- Reset (rst_n low, async): state IDLE, sync chain 0, counters 0, period=0, high_time=0, period_valid=0, timeout=0, busy=0.
- sig_in passes through SYNC_STAGES flops plus one history flop; rise = sync & ~hist, fall = ~sync & hist. Edge detect latency from sig_in to internal edge is SYNC_STAGES+1 cycles.
- States:
  - IDLE: counters held at 0. meas_en=1 moves to ARM next cycle.
  - ARM: waits for rise; falls ignored. On rise: cnt<=1, hcnt<=1, go MEASURE, no valid pulse.
  - MEASURE:
    - Each cycle without rise: cnt increments; hcnt increments while sync=1 and no fall seen since the last rise.
    - On rise: period<=cnt, high_time<=hcnt, period_valid=1 for exactly that cycle, timeout<=0, then cnt<=1, hcnt<=1. Stay in MEASURE.
- Counting rule: rises on cycles t0 and t1 give period = t1-t0. For a signal toggling every N clk_in cycles: period=2N, high_time=N.
- Timeout: in ARM or MEASURE, if cnt reaches TIMEOUT_CYC with no rise:
  - timeout<=1; go ARM.
  - period/high_time hold; no valid pulse; cnt saturates, never wraps.
  - In ARM, cnt counts from entry for the timeout check only.
- meas_en deasserted in any state: IDLE next cycle, counters cleared, period/high_time/timeout hold, period_valid=0. meas_en low overrides a simultaneous rise.
- A rise on the same cycle cnt hits TIMEOUT_CYC is a valid measurement; the edge wins over timeout.
- busy = (state != IDLE), registered.
- Outputs change only on clk_in edges or async reset. period_valid is never high for 2 consecutive cycles; the minimum measurable period is 2.
- Mid-operation reset: immediate return to reset values; the first valid pulse after re-enable requires two rises.

Test Plan:
- Reset, meas_en=1, sig_in from a divider toggling every 3 clk_in cycles -> first period_valid after the 2nd detected rise; period=6, high_time=3; then pulses every 6 cycles.
- sig_in high 5, low 11 cycles repeating -> period=16, high_time=5 on every valid pulse; period_valid width exactly 1 cycle.
- TIMEOUT_CYC=100, sig_in held low after 2 valid periods -> timeout=1 at 100 cycles after the last rise; period holds its old value; valid stays 0. Restart toggling -> first new valid (two rises) clears timeout.
- Drop meas_en mid-period, then re-raise -> busy=0 the next cycle, no valid pulse; after re-enable the first valid comes only after two rises, with a correct period.
- rst_n pulsed low asynchronously mid-MEASURE (not clock-aligned) -> all outputs 0 immediately; no spurious valid after release.
- sig_in toggling every clk_in cycle (period 2) -> period=2, high_time=1, period_valid pulses every other cycle.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow, asynchronous square
// wave in clk_in cycles, with a sticky timeout when rising edges stop arriving.
module period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic                   fall_seen_q, fall_seen_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;

    logic             sync_bit;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt_inc;

    // Synchronizer shift, edge detection and saturating increments.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
        sync_bit = sync_q[SYNC_STAGES-1];
        hist_d   = sync_bit;
        rise     = sync_bit & ~hist_q;
        fall     = ~sync_bit & hist_q;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 1'b1;
    end

    // Next-state and datapath: an edge on the timeout cycle still counts as a
    // measurement; meas_en low overrides everything and returns to IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        fall_seen_d = fall_seen_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                hcnt_d      = '0;
                fall_seen_d = 1'b0;
                if (meas_en) state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    cnt_d       = CNT_W'(1);
                    hcnt_d      = CNT_W'(1);
                    fall_seen_d = 1'b0;
                    state_d     = MEASURE;
                end else if (cnt_q >= TO_LIM) begin
                    // Re-arm the timeout window; flag stays set.
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d    = cnt_q;
                    high_d      = hcnt_q;
                    valid_d     = 1'b1;
                    timeout_d   = 1'b0;
                    cnt_d       = CNT_W'(1);
                    hcnt_d      = CNT_W'(1);
                    fall_seen_d = 1'b0;
                end else if (cnt_q >= TO_LIM) begin
                    timeout_d   = 1'b1;
                    state_d     = ARM;
                    cnt_d       = '0;
                    hcnt_d      = '0;
                    fall_seen_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (fall) fall_seen_d = 1'b1;
                    if (sync_bit && !fall_seen_q) hcnt_d = hcnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!meas_en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            hcnt_d      = '0;
            fall_seen_d = 1'b0;
            valid_d     = 1'b0;
            period_d    = period_q;
            high_d      = high_q;
            timeout_d   = timeout_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            hist_q      <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            fall_seen_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            fall_seen_q <= fall_seen_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter with a small timeout limit.
module tb_period_meter;

    localparam int CNT_W       = 32;
    localparam int TIMEOUT_CYC = 100;
    localparam int SYNC_STAGES = 2;

    logic             clk_in;
    logic             rst_n;
    logic             sig_in;
    logic             meas_en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Square-wave generator controls.
    bit gen_en = 0;
    int hi_len = 3;
    int lo_len = 3;
    int ph     = 0;

    period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .meas_en     (meas_en),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    // Clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Generator: hi_len cycles high, lo_len cycles low, updated away from the edge.
    always @(posedge clk_in) begin
        #2;
        if (!gen_en) begin
            sig_in = 1'b0;
            ph     = 0;
        end else begin
            sig_in = (ph < hi_len);
            ph     = (ph + 1 == hi_len + lo_len) ? 0 : ph + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Wait up to budget cycles for a valid pulse; reports cycles waited.
    task automatic wait_valid(input int budget, output int cycles, output bit got);
        got    = 0;
        cycles = 0;
        while (cycles < budget && !got) begin
            tick();
            cycles++;
            if (period_valid) got = 1;
        end
    endtask

    task automatic restart(input int hi, input int lo);
        meas_en = 1'b0;
        gen_en  = 0;
        repeat (4) tick();
        hi_len  = hi;
        lo_len  = lo;
        gen_en  = 1;
        meas_en = 1'b1;
    endtask

    int cyc;
    bit got;
    int pulses;

    initial begin
        rst_n   = 1'b0;
        meas_en = 1'b0;
        sig_in  = 1'b0;
        #23;
        check_eq("rst_period", period, 0);
        check_eq("rst_high", high_time, 0);
        check_eq("rst_valid", period_valid, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Divider toggling every 3 cycles.
        restart(3, 3);
        wait_valid(60, cyc, got);
        check_eq("d3_got", got, 1);
        check_eq("d3_period", period, 6);
        check_eq("d3_high", high_time, 3);
        tick();
        check_eq("d3_width", period_valid, 0);
        wait_valid(60, cyc, got);
        check_eq("d3_spacing", cyc, 5);
        check_eq("d3_period2", period, 6);
        wait_valid(60, cyc, got);
        check_eq("d3_spacing2", cyc, 6);

        // High 5, low 11.
        restart(5, 11);
        for (int i = 0; i < 3; i++) begin
            wait_valid(80, cyc, got);
            check_eq("h5_got", got, 1);
            check_eq("h5_period", period, 16);
            check_eq("h5_high", high_time, 5);
            tick();
            check_eq("h5_width", period_valid, 0);
        end

        // Drop meas_en mid-period.
        repeat (4) tick();
        meas_en = 1'b0;
        tick();
        check_eq("dis_busy", busy, 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (period_valid) pulses++;
        end
        check_eq("dis_no_valid", pulses, 0);
        check_eq("dis_period_hold", period, 16);
        meas_en = 1'b1;
        wait_valid(80, cyc, got);
        check_eq("reen_got", got, 1);
        check_eq("reen_two_rises", (cyc >= 18), 1);
        check_eq("reen_period", period, 16);
        check_eq("reen_high", high_time, 5);

        // Timeout after the signal stops.
        restart(3, 3);
        wait_valid(60, cyc, got);
        wait_valid(60, cyc, got);
        check_eq("to_pre_got", got, 1);
        gen_en = 0;
        cyc    = 0;
        pulses = 0;
        while (!timeout && cyc < 300) begin
            tick();
            cyc++;
            if (period_valid) pulses++;
        end
        check_eq("to_cycles", cyc, TIMEOUT_CYC);
        check_eq("to_no_valid", pulses, 0);
        check_eq("to_period_hold", period, 6);
        check_eq("to_busy_arm", busy, 1);
        repeat (150) tick();
        check_eq("to_sticky", timeout, 1);
        gen_en = 1;
        wait_valid(60, cyc, got);
        check_eq("to_recover_got", got, 1);
        check_eq("to_cleared", timeout, 0);
        check_eq("to_recover_period", period, 6);

        // Fastest signal: period 2.
        restart(1, 1);
        wait_valid(40, cyc, got);
        check_eq("p2_got", got, 1);
        check_eq("p2_period", period, 2);
        check_eq("p2_high", high_time, 1);
        tick();
        check_eq("p2_gap", period_valid, 0);
        tick();
        check_eq("p2_next", period_valid, 1);
        check_eq("p2_period2", period, 2);

        // Asynchronous reset mid-measure.
        restart(3, 3);
        wait_valid(60, cyc, got);
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_period", period, 0);
        check_eq("arst_high", high_time, 0);
        check_eq("arst_valid", period_valid, 0);
        check_eq("arst_timeout", timeout, 0);
        check_eq("arst_busy", busy, 0);
        #12;
        rst_n = 1'b1;
        wait_valid(60, cyc, got);
        check_eq("arst_got", got, 1);
        check_eq("arst_two_rises", (cyc >= 8), 1);
        check_eq("arst_period_after", period, 6);
        check_eq("arst_high_after", high_time, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
